// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serializes a {segment, digit-select} frame into a chain of
// two 74HC595 shift registers. One frame is FRAME_BITS bits; each bit takes
// four sys_clk cycles (ds update, idle, shcp rise, frame bookkeeping).
// sel[0] is shifted first and seg[0] last, then stcp latches the frame.
module hc595_ctrl #(
  parameter int SEL_W = 6,
  parameter int SEG_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEG_W-1:0] seg,
  output logic             stcp,
  output logic             shcp,
  output logic             ds,
  output logic             oe
);

  localparam int FRAME_BITS = SEL_W + SEG_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  // Phases of the 4-cycle bit slot, named by what happens on that edge.
  localparam logic [1:0] PH_DS   = 2'd0;  // present next bit, shcp falls
  localparam logic [1:0] PH_RISE = 2'd2;  // shcp rises, 595 samples ds
  localparam logic [1:0] PH_LAST = 2'd3;  // advance bit index / end frame

  logic [1:0]            cnt_4_q,   cnt_4_d;
  logic [CNT_W-1:0]      cnt_bit_q, cnt_bit_d;
  logic [FRAME_BITS-1:0] data_q,    data_d;
  logic                  ds_q,      ds_d;
  logic                  shcp_q,    shcp_d;
  logic                  stcp_q,    stcp_d;

  logic [FRAME_BITS-1:0] frame_new;
  logic                  frame_end;

  // Last edge of the last bit slot: capture the next frame and latch this one.
  assign frame_end = (cnt_4_q == PH_LAST) && (cnt_bit_q == LAST_BIT);

  // Build the frame: sel in the low bits, seg bit-reversed above it so that
  // seg[0] lands in the final shifted position.
  always_comb begin
    frame_new = '0;
    frame_new[SEL_W-1:0] = sel;
    for (int i = 0; i < SEG_W; i++) begin
      frame_new[FRAME_BITS-1-i] = seg[i];
    end
  end

  // Next-state logic for counters, frame register and pin registers.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    cnt_4_d   = cnt_4_q + 2'd1;
    cnt_bit_d = cnt_bit_q;
    data_d    = data_q;
    ds_d      = ds_q;
    shcp_d    = shcp_q;
    stcp_d    = frame_end;

    if (cnt_4_q == PH_LAST) begin
      cnt_bit_d = (cnt_bit_q == LAST_BIT) ? '0 : cnt_bit_q + 1'b1;
    end

    if (frame_end) begin
      data_d = frame_new;
    end

    if (cnt_4_q == PH_DS) begin
      ds_d   = data_q[cnt_bit_q];
      shcp_d = 1'b0;
    end else if (cnt_4_q == PH_RISE) begin
      shcp_d = 1'b1;
    end
  end

  // State registers; reset clears everything so a fresh frame starts at bit 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_4_q   <= '0;
      cnt_bit_q <= '0;
      data_q    <= '0;
      ds_q      <= 1'b0;
      shcp_q    <= 1'b0;
      stcp_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      cnt_4_q   <= cnt_4_d;
      cnt_bit_q <= cnt_bit_d;
      data_q    <= data_d;
      ds_q      <= ds_d;
      shcp_q    <= shcp_d;
      stcp_q    <= stcp_d;
    end
  end

  assign ds   = ds_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  // Outputs of the 595s stay disabled while the controller is held in reset.
  assign oe   = ~sys_rst_n;

endmodule

// File: tb/tb_hc595_ctrl.sv
// Directed bench for hc595_ctrl: reset values, shcp/stcp timing, frame
// content and ordering, tear-free capture, mid-frame reset, and a 595-chain
// model comparing latched values against the inputs captured per frame.
module tb_hc595_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       stcp, shcp, ds, oe;

  int n_tests = 0;
  int n_fail  = 0;

  hc595_ctrl #(.SEL_W(6), .SEG_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sel       (sel),
    .seg       (seg),
    .stcp      (stcp),
    .shcp      (shcp),
    .ds        (ds),
    .oe        (oe)
  );

  // 50 MHz
  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: past the rising edge, then sample on the falling edge.
  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Value held in the 595 chain after 14 shifts of a frame: the first bit
  // shifted (data[0]) ends up at the far end, bit 13.
  function automatic logic [13:0] chain_value(input logic [5:0] s, input logic [7:0] g);
    logic [13:0] d;
    logic [13:0] r;
    d[5:0] = s;
    for (int i = 0; i < 8; i++) d[13-i] = g[i];
    for (int k = 0; k < 14; k++) r[13-k] = d[k];
    return r;
  endfunction

  initial begin
    logic        shcp_prev;
    logic [13:0] fr [0:3];
    logic [13:0] sr;
    logic [13:0] exp_latch;
    int          rises, fidx, bidx, n, frames, cycles;
    bit          seen;

    // ---- 1: reset values ------------------------------------------------
    sys_rst_n = 1'b0;
    sel = 6'b000110;
    seg = 8'b00001010;
    #1;
    check("rst_oe_t1",   oe,   1'b1);
    check("rst_stcp_t1", stcp, 1'b0);
    check("rst_shcp_t1", shcp, 1'b0);
    check("rst_ds_t1",   ds,   1'b0);
    #44;
    check("rst_oe_t45",   oe,   1'b1);
    check("rst_outs_t45", {stcp, shcp, ds}, 3'b000);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check("oe_after_release", oe, 1'b0);

    // ---- 2/3/4: timing, frame content, mid-frame input change -----------
    shcp_prev = 1'b0;
    rises = 0; fidx = 0; bidx = 0;
    for (int f = 0; f < 4; f++) fr[f] = 'x;
    for (int j = 0; j < 224; j++) begin
      step();
      check("shcp_phase", shcp, ((j % 4) >= 2));
      check("stcp_phase", stcp, ((j % 56) == 55));
      if (shcp && !shcp_prev) begin
        rises++;
        if (fidx < 4) fr[fidx][bidx] = ds;
        bidx++;
        if (bidx == 14) begin
          bidx = 0;
          fidx++;
        end
      end
      if (stcp) begin
        check("rises_between_stcp", rises, 14);
        rises = 0;
      end
      shcp_prev = shcp;
      if (j == 78) seg = 8'hFF;   // middle of frame 2
    end
    check("frame1_zeros",     fr[0], 14'b00000000000000);
    check("frame2_bits",      fr[1], 14'b01010000000110);
    check("frame3_seg_ff",    fr[2], 14'b11111111000110);
    check("frame4_seg_ff",    fr[3], 14'b11111111000110);

    // ---- 5: reset in the middle of bit 7 --------------------------------
    for (int j = 224; j <= 254; j++) step();
    check("pre_rst_ds",   ds,   1'b1);
    check("pre_rst_shcp", shcp, 1'b1);
    check("pre_rst_stcp", stcp, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_outs", {stcp, shcp, ds}, 3'b000);
    check("midrst_oe",   oe, 1'b1);
    @(negedge sys_clk);
    check("midrst_hold_outs", {stcp, shcp, ds}, 3'b000);
    sys_rst_n = 1'b1;
    #1;
    check("midrst_release_oe", oe, 1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      step();
      n++;
      if (stcp) seen = 1'b1;
    end
    check("stcp_after_rst_seen",    seen, 1'b1);
    check("stcp_after_rst_latency", n,    56);

    // ---- 6: 595 chain model over 1000 frames with random inputs ---------
    exp_latch = chain_value(sel, seg);
    sr        = '0;
    shcp_prev = shcp;
    frames    = 0;
    cycles    = 0;
    while (frames < 1000 && cycles < 57000) begin
      step();
      cycles++;
      if (shcp && !shcp_prev) sr = {sr[12:0], ds};
      shcp_prev = shcp;
      if (stcp) begin
        check("latched_frame", sr, exp_latch);
        exp_latch = chain_value(sel, seg);
        frames++;
      end
      if ($urandom_range(7) == 0) begin
        sel = 6'($urandom);
        seg = 8'($urandom);
      end
    end
    check("model_frames_done", frames, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
